// File: rtl/ctrl_pkg.sv
// Shared encodings and the ID/EX control bundle for the RV32IM control unit.
// The M-extension fields exist only when RV32M_EXT_EN is defined.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MDU  = 7'b0000001;

    typedef enum logic [2:0] {
        ALU_R    = 3'b000,
        ALU_LOAD = 3'b001,
        ALU_JALR = 3'b010,
        ALU_IMM  = 3'b011
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_U = 3'b010,
        IMM_B = 3'b011,
        IMM_J = 3'b100
    } imm_pick_e;

    typedef enum logic [1:0] {
        WB_BYTE = 2'b00,
        WB_HALF = 2'b01,
        WB_WORD = 2'b10
    } wb_method_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MDU_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic       write_en;
        logic       mem_write;
        logic       mem_read;
        logic       branch;
        logic       jump;
        logic       pc_select;
        logic       imm_select;
        logic       jal_select;
        wb_method_e wb_method;
        imm_pick_e  imm_pick;
        alu_op_e    alu_op;
`ifdef RV32M_EXT_EN
        logic [2:0] mdu_op;
        logic       mdu_sel;
`endif
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I(M) control decode; M-extension gated by RV32M_EXT_EN.
// Illegal encodings collapse to an all-zero bundle with only illegal set.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] i_instr,
    output ctrl_t       o_ctrl
);

    logic [6:0] w_opcode;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_legal;
    ctrl_t      w_ctrl;
    logic       w_unused_bits;

    assign w_opcode      = i_instr[6:0];
    assign w_f3          = i_instr[14:12];
    assign w_f7          = i_instr[31:25];
    assign w_unused_bits = ^{i_instr[24:15], i_instr[11:7]};

    always_comb begin
        w_ctrl  = '0;
        w_legal = 1'b1;
        unique case (w_opcode)
            OP_R: begin
                if (w_f7 == F7_BASE ||
                    (w_f7 == F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101))) begin
                    w_ctrl.write_en = 1'b1;
                end
`ifdef RV32M_EXT_EN
                else if (w_f7 == F7_MDU) begin
                    w_ctrl.write_en = 1'b1;
                    w_ctrl.mdu_sel  = 1'b1;
                    w_ctrl.mdu_op   = w_f3;
                end
`endif
                else begin
                    w_legal = 1'b0;
                end
            end
            OP_LOAD: begin
                w_legal           = (w_f3 != 3'b011 && w_f3 != 3'b110 &&
                                     w_f3 != 3'b111);
                w_ctrl.imm_select = 1'b1;
                w_ctrl.write_en   = 1'b1;
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.alu_op     = ALU_LOAD;
            end
            OP_JALR: begin
                w_legal           = (w_f3 == 3'b000);
                w_ctrl.write_en   = 1'b1;
                w_ctrl.jal_select = 1'b1;
                w_ctrl.imm_select = 1'b1;
                w_ctrl.jump       = 1'b1;
                w_ctrl.alu_op     = ALU_JALR;
            end
            OP_IMM: begin
                // Shift-immediates reuse FUNC7 as an encoding field
                if (w_f3 == 3'b001) begin
                    w_legal = (w_f7 == F7_BASE);
                end else if (w_f3 == 3'b101) begin
                    w_legal = (w_f7 == F7_BASE || w_f7 == F7_ALT);
                end
                w_ctrl.write_en   = 1'b1;
                w_ctrl.imm_select = 1'b1;
                w_ctrl.alu_op     = ALU_IMM;
            end
            OP_STORE: begin
                w_legal           = (w_f3 == 3'b000 || w_f3 == 3'b001 ||
                                     w_f3 == 3'b010);
                w_ctrl.mem_write  = 1'b1;
                w_ctrl.imm_select = 1'b1;
                w_ctrl.imm_pick   = IMM_S;
                w_ctrl.wb_method  = wb_method_e'(w_f3[1:0]);
            end
            OP_LUI, OP_AUIPC: begin
                w_ctrl.write_en   = 1'b1;
                w_ctrl.imm_select = 1'b1;
                w_ctrl.imm_pick   = IMM_U;
                w_ctrl.pc_select  = (w_opcode == OP_AUIPC);
            end
            OP_BRANCH: begin
                w_legal           = (w_f3 != 3'b010 && w_f3 != 3'b011);
                w_ctrl.branch     = 1'b1;
                w_ctrl.pc_select  = 1'b1;
                w_ctrl.imm_select = 1'b1;
                w_ctrl.imm_pick   = IMM_B;
            end
            OP_JAL: begin
                w_ctrl.jump       = 1'b1;
                w_ctrl.jal_select = 1'b1;
                w_ctrl.pc_select  = 1'b1;
                w_ctrl.imm_select = 1'b1;
                w_ctrl.write_en   = 1'b1;
                w_ctrl.imm_pick   = IMM_J;
            end
            default: w_legal = 1'b0;
        endcase
        if (!w_legal) begin
            w_ctrl         = '0;
            w_ctrl.illegal = 1'b1;
        end
    end

    assign o_ctrl = w_ctrl;

endmodule

// File: rtl/pipelined_control_unit.sv
// ID/EX control register with multi-cycle MDU wait FSM (RV32M_EXT_EN).
// Without RV32M_EXT_EN the FSM and counter are not built.
module pipelined_control_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned MUL_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        INSTR_VALID,
    input  logic [31:0] INSTR,
    output logic        INSTR_READY,
    input  logic        STALL_IN,
    input  logic        FLUSH,
    output logic        EX_VALID,
    output logic        WRITE_EN,
    output logic        MEM_WRITE,
    output logic        MEM_READ,
    output logic        BRANCH,
    output logic        JUMP,
    output logic        PC_SELECT,
    output logic        IMM_SELECT,
    output logic        JAL_SELECT,
    output logic [1:0]  WB_METHOD,
    output logic [2:0]  IMM_PICK,
    output logic [2:0]  ALU_OP,
    output logic [2:0]  MDU_OP,
    output logic        MDU_SEL,
    output logic        ILLEGAL,
    output logic        MDU_BUSY
);

    if (DIV_CYCLES < 1 || DIV_CYCLES > 255 ||
        MUL_CYCLES < 1 || MUL_CYCLES > 255) begin : g_bad_cfg
        $error("DIV_CYCLES and MUL_CYCLES must be in 1..255");
    end

    ctrl_t w_dec;
    ctrl_t r_ctrl;
    ctrl_t w_ctrl_nxt;
    logic  r_ex_valid;
    logic  w_valid_nxt;
    logic  w_idle;
    logic  w_accept;

    ctrl_decode u_decode (
        .i_instr (INSTR),
        .o_ctrl  (w_dec)
    );

`ifdef RV32M_EXT_EN
    localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);
    localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 1);

    state_e     r_state;
    state_e     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;

    assign w_idle = (r_state == ST_IDLE);
`else
    assign w_idle = 1'b1;
`endif

    assign INSTR_READY = !STALL_IN && w_idle;
    assign w_accept    = INSTR_VALID && INSTR_READY && !FLUSH;

    always_comb begin
        w_ctrl_nxt  = r_ctrl;
        w_valid_nxt = r_ex_valid;
`ifdef RV32M_EXT_EN
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
`endif
        if (FLUSH) begin
            w_ctrl_nxt  = '0;
            w_valid_nxt = 1'b0;
`ifdef RV32M_EXT_EN
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
`endif
        end else if (STALL_IN) begin
            w_ctrl_nxt  = r_ctrl;
        end
`ifdef RV32M_EXT_EN
        else if (!w_idle) begin
            // Issued bundle stays visible but is only live for one cycle
            w_valid_nxt = 1'b0;
            if (r_cnt == 8'd0) begin
                w_state_nxt = ST_IDLE;
            end else begin
                w_cnt_nxt = r_cnt - 8'd1;
            end
        end
`endif
        else if (w_accept) begin
            w_ctrl_nxt  = w_dec;
            w_valid_nxt = 1'b1;
`ifdef RV32M_EXT_EN
            if (w_dec.mdu_sel) begin
                if (w_dec.mdu_op[2]) begin
                    w_cnt_nxt   = DIV_LOAD;
                    w_state_nxt = ST_MDU_WAIT;
                end else if (MUL_CYCLES > 1) begin
                    w_cnt_nxt   = MUL_LOAD;
                    w_state_nxt = ST_MDU_WAIT;
                end
            end
`endif
        end else begin
            w_ctrl_nxt  = '0;
            w_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_ctrl     <= '0;
            r_ex_valid <= 1'b0;
        end else begin
            r_ctrl     <= w_ctrl_nxt;
            r_ex_valid <= w_valid_nxt;
        end
    end

`ifdef RV32M_EXT_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign MDU_SEL  = r_ctrl.mdu_sel;
    assign MDU_OP   = r_ctrl.mdu_op;
    assign MDU_BUSY = (r_state == ST_MDU_WAIT);
`else
    assign MDU_SEL  = 1'b0;
    assign MDU_OP   = 3'b000;
    assign MDU_BUSY = 1'b0;
`endif

    assign EX_VALID   = r_ex_valid;
    assign WRITE_EN   = r_ctrl.write_en;
    assign MEM_WRITE  = r_ctrl.mem_write;
    assign MEM_READ   = r_ctrl.mem_read;
    assign BRANCH     = r_ctrl.branch;
    assign JUMP       = r_ctrl.jump;
    assign PC_SELECT  = r_ctrl.pc_select;
    assign IMM_SELECT = r_ctrl.imm_select;
    assign JAL_SELECT = r_ctrl.jal_select;
    assign WB_METHOD  = r_ctrl.wb_method;
    assign IMM_PICK   = r_ctrl.imm_pick;
    assign ALU_OP     = r_ctrl.alu_op;
    assign ILLEGAL    = r_ctrl.illegal;

endmodule

// File: doc/pipelined_control_unit.md
PIPELINED_CONTROL_UNIT -- requirements
Module: pipelined_control_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter DIV_CYCLES, default 32, SHALL set the number of stall cycles for DIV/DIVU/REM/REMU, with legal range 1..255.
REQ-003 Parameter MUL_CYCLES, default 1, SHALL set the number of stall cycles for MUL/MULH/MULHSU/MULHU, with legal range 1..255, where 1 means no stall.
REQ-004 The ports SHALL be, one per line as name, direction, width, meaning:
CLK  in  1  clock, rising edge
RESET_N  in  1  async active-low reset
INSTR_VALID  in  1  INSTR holds a fetched instruction
INSTR  in  32  raw RV32IM instruction
INSTR_READY  out  1  decoder accepts INSTR this cycle
STALL_IN  in  1  downstream stall; hold ID/EX bundle
FLUSH  in  1  taken branch/jump; kill bundle and wait state
EX_VALID  out  1  bundle below is a live instruction
WRITE_EN, MEM_WRITE, MEM_READ, BRANCH, JUMP, PC_SELECT, IMM_SELECT, JAL_SELECT  out  1 each  registered control bits
WB_METHOD  out  2  store width: 00 byte, 01 half, 10 word
IMM_PICK  out  3  immediate format: 000 I, 001 S, 010 U, 011 B, 100 J
ALU_OP  out  3  000 R, 001 load, 010 JALR, 011 I-arith
MDU_OP  out  3  FUNC3 of an M-extension instruction; valid when MDU_SEL is 1
MDU_SEL  out  1  bundle is an M-extension instruction
ILLEGAL  out  1  bundle is an undecodable instruction
MDU_BUSY  out  1  multi-cycle multiply/divide wait in progress

Function
REQ-005 The combinational decode SHALL follow the RV32I control table:
- R-type: WRITE_EN.
- Loads, FUNC3 000/001/010/100/101: IMM_SELECT, WRITE_EN, MEM_READ, ALU_OP 001.
- JALR: WRITE_EN, JAL_SELECT, IMM_SELECT, JUMP, ALU_OP 010.
- OP-IMM: WRITE_EN, IMM_SELECT, ALU_OP 011. Shift-immediates SHALL be legal only with FUNC7 0000000, or 0100000 for SRAI.
- Stores SB/SH/SW: MEM_WRITE, IMM_SELECT, IMM_PICK 001, WB_METHOD 00/01/10.
- LUI: WRITE_EN, IMM_SELECT, IMM_PICK 010. AUIPC: as LUI plus PC_SELECT.
- Branches, FUNC3 not 010/011: BRANCH, PC_SELECT, IMM_SELECT, IMM_PICK 011.
- JAL: JUMP, JAL_SELECT, PC_SELECT, IMM_SELECT, WRITE_EN, IMM_PICK 100.
REQ-006 Any other encoding SHALL produce an all-zero bundle with ILLEGAL=1.
REQ-007 INSTR_READY SHALL equal !STALL_IN && state==IDLE.
REQ-008 An instruction SHALL be accepted when INSTR_VALID && INSTR_READY && !FLUSH.
REQ-009 On accept, the decoded bundle SHALL appear registered on the next edge with EX_VALID=1, giving 1-cycle latency.
REQ-010 When idle, not stalled and with no accept, the next edge SHALL load a bubble: EX_VALID=0 and all control outputs 0.
REQ-011 While STALL_IN=1 and FLUSH=0, all outputs, the state and the counter SHALL hold.
REQ-012 FLUSH SHALL win over STALL_IN and over accept: the next edge SHALL load a bubble, set state to IDLE, clear the counter and drop MDU_BUSY.
REQ-013 The FSM SHALL have states IDLE and MDU_WAIT.
REQ-014 An accepted divide SHALL load the counter with DIV_CYCLES-1 and enter MDU_WAIT.
REQ-015 An accepted multiply with MUL_CYCLES>1 SHALL load the counter with MUL_CYCLES-1 and enter MDU_WAIT; with MUL_CYCLES=1 the state SHALL stay IDLE.
REQ-016 In MDU_WAIT:
- MDU_BUSY SHALL be 1.
- The issued bundle SHALL stay on the outputs with EX_VALID=1 for its first cycle only and 0 thereafter.
- The counter SHALL decrement each unstalled cycle; at 0 the FSM SHALL return to IDLE on the next edge.
REQ-017 The counter SHALL be 8 bits wide and SHALL never wrap below 0.

Reset
REQ-018 While RESET_N=0, immediately and independent of CLK:
- EX_VALID, all control outputs, MDU_SEL, MDU_OP, ILLEGAL and MDU_BUSY SHALL be 0.
- State SHALL be IDLE and the counter 0.
REQ-019 Reset asserted during MDU_WAIT SHALL abort the wait, and the first accept after release SHALL be at the first edge where the conditions of REQ-008 hold.

Configuration
REQ-020 With macro RV32M_EXT_EN defined, FUNC7=0000001 on the R-type opcode SHALL decode as M-extension: WRITE_EN=1, MDU_SEL=1, MDU_OP=FUNC3, with multi-cycle waits.
REQ-021 With RV32M_EXT_EN undefined, such encodings SHALL be ILLEGAL, MDU_SEL/MDU_OP/MDU_BUSY SHALL be tied 0, and the FSM and counter SHALL be absent.

Structure
REQ-022 Package ctrl_pkg SHALL hold the opcode constants, the ALU_OP, IMM_PICK and WB_METHOD encodings, the FSM state typedef and the control-bundle struct typedef.
REQ-023 The combinational decode SHALL be sub-module ctrl_decode; the registers and FSM SHALL live in pipelined_control_unit.

Verification
REQ-024 Reset and ADDI: release reset, then INSTR=0x00500093 (ADDI x1,x0,5) with valid -> next cycle EX_VALID=1, WRITE_EN=1, IMM_SELECT=1, ALU_OP=011, all else 0.
REQ-025 Store under stall: INSTR=0x0020A023 (SW), STALL_IN=1 for 3 cycles after issue -> MEM_WRITE=1, WB_METHOD=10, IMM_PICK=001 held for 3 cycles, INSTR_READY=0 throughout.
REQ-026 Divide wait: with DIV_CYCLES=4 and RV32M_EXT_EN defined, INSTR=0x0220C1B3 (DIV x3,x1,x2) -> MDU_SEL=1, MDU_OP=100, EX_VALID for 1 cycle, MDU_BUSY=1 and INSTR_READY=0 for 4 cycles, then READY=1.
REQ-027 Flush during divide: FLUSH=1 in the 2nd wait cycle -> next cycle MDU_BUSY=0, EX_VALID=0, INSTR_READY=1.
REQ-028 Illegal encoding: INSTR=0xFFFFFFFF -> ILLEGAL=1, EX_VALID=1, all other controls 0.
REQ-029 M-extension compiled out: INSTR=0x0220C1B3 without RV32M_EXT_EN -> ILLEGAL=1.
